// File: rtl/uart_imem_loader_if.sv
// Byte stream in from the UART receiver, word writes out to the instruction memory.
interface uart_imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_valid, rx_data, rx_break,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data, rx_break,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Assembles UART bytes (LSB first) into 32-bit words and writes them sequentially
// into instruction memory until a terminator word or a full memory ends the load.
module uart_imem_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  uart_imem_loader_if.slave bus,
  output logic              load_active,
  output logic              write_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              rx_prev_q;
  logic              rx_rise;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       byte_ins;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              active_q, active_d;

  // Only a low-to-high transition of rx_valid carries a new byte.
  assign rx_rise = bus.rx_valid & ~rx_prev_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (!bus.rx_break && rx_rise && (idx_q == 2'd3)) begin
          state_d = CHECK;
        end
      end
      CHECK:   state_d = (word_q == END_WORD) ? DONE : WRITE;
      WRITE:   state_d = (addr_q == LAST_ADDR) ? DONE : COLLECT;
      DONE:    state_d = DONE;
      default: state_d = COLLECT;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    idx_d    = idx_q;
    shift_d  = shift_q;
    word_d   = word_q;
    addr_d   = addr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q;
    byte_ins = shift_q;
    byte_ins[{idx_q, 3'b000} +: 8] = bus.rx_data;

    unique case (state_q)
      COLLECT: begin
        if (bus.rx_break) begin
          idx_d   = 2'd0;
          shift_d = 32'd0;
        end else if (rx_rise) begin
          if (idx_q == 2'd3) begin
            word_d  = byte_ins;
            shift_d = 32'd0;
            idx_d   = 2'd0;
          end else begin
            shift_d = byte_ins;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      CHECK: begin
        if (rx_rise) begin
          shift_d = byte_ins;
          idx_d   = idx_q + 2'd1;
        end
        if (word_q == END_WORD) begin
          done_d = 1'b1;
        end else begin
          we_d = 1'b1;
        end
      end
      WRITE: begin
        if (rx_rise) begin
          shift_d = byte_ins;
          idx_d   = idx_q + 2'd1;
        end
        count_d = count_q + CNT_W'(1);
        // The address holds at the last slot so it can never wrap back over written words.
        if (addr_q == LAST_ADDR) begin
          ovf_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase

    active_d = ~done_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q <= 1'b0;
      idx_q     <= 2'd0;
      shift_q   <= 32'd0;
      word_q    <= 32'd0;
      addr_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      active_q  <= 1'b1;
    end else begin
      rx_prev_q <= bus.rx_valid;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      active_q  <= active_d;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign load_active   = active_q;
  assign write_done    = done_q;
  assign overflow      = ovf_q;
  assign word_count    = count_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed and randomized byte streams into two loaders (full-size and 4-deep),
// checked against a word-level reference model of the load protocol.
module tb_uart_imem_loader;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(8)) ifa ();
  uart_imem_loader_if #(.ADDR_W(8)) ifb ();

  assign ifa.rx_valid = rx_valid & ~sel;
  assign ifa.rx_data  = rx_data;
  assign ifa.rx_break = rx_break & ~sel;
  assign ifb.rx_valid = rx_valid & sel;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_break = rx_break & sel;

  logic       la_a, wd_a, ov_a, la_b, wd_b, ov_b;
  logic [8:0] wc_a, wc_b;

  uart_imem_loader #(.ADDR_W(8), .DEPTH(256), .END_WORD(END_W)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave),
    .load_active(la_a), .write_done(wd_a), .overflow(ov_a), .word_count(wc_a)
  );

  uart_imem_loader #(.ADDR_W(8), .DEPTH(4), .END_WORD(END_W)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave),
    .load_active(la_b), .write_done(wd_b), .overflow(ov_b), .word_count(wc_b)
  );

  // Observed outputs of whichever loader is under test
  logic        o_we, o_la, o_wd, o_ov;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  logic [8:0]  o_wc;
  assign o_we    = sel ? ifb.mem_we    : ifa.mem_we;
  assign o_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
  assign o_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
  assign o_la    = sel ? la_b : la_a;
  assign o_wd    = sel ? wd_b : wd_a;
  assign o_ov    = sel ? ov_b : ov_a;
  assign o_wc    = sel ? wc_b : wc_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  logic [7:0] md_bytes[$];
  int   md_addr, md_depth;
  bit   md_done, md_ovf;
  int   exp_done_cyc = -1;
  int   done_cyc = -1;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and completion monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (o_we) obs_q.push_back('{int'(o_addr), o_wdata, cyc});
      if (o_wd && !done_prev) done_cyc = cyc;
    end
    done_prev = o_wd;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // Reference model: complete groups of four bytes form a word; write or terminate.
  function automatic void model_byte(input logic [7:0] b, input int rise);
    logic [31:0] w;
    if (md_done) return;
    md_bytes.push_back(b);
    if (md_bytes.size() == 4) begin
      w = {md_bytes[3], md_bytes[2], md_bytes[1], md_bytes[0]};
      md_bytes.delete();
      if (w == END_W) begin
        md_done = 1'b1;
        exp_done_cyc = rise + 2;
      end else begin
        exp_q.push_back('{md_addr, w, rise + 2});
        md_addr++;
        if (md_addr == md_depth) begin
          md_done = 1'b1;
          md_ovf = 1'b1;
          exp_done_cyc = rise + 3;
        end
      end
    end
  endfunction

  task automatic reset_now(input logic s, input int depth);
    sel = s;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mem_we", 64'(o_we), 64'(0));
    chk("rst_mem_addr", 64'(o_addr), 64'(0));
    chk("rst_mem_wdata", 64'(o_wdata), 64'(0));
    chk("rst_word_count", 64'(o_wc), 64'(0));
    chk("rst_write_done", 64'(o_wd), 64'(0));
    chk("rst_overflow", 64'(o_ov), 64'(0));
    chk("rst_load_active", 64'(o_la), 64'(1));
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    md_bytes.delete();
    md_addr = 0;
    md_depth = depth;
    md_done = 1'b0;
    md_ovf = 1'b0;
    exp_done_cyc = -1;
    done_cyc = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    model_byte(b, cyc);
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[8*i +: 8], int'($urandom_range(1, 3)), int'($urandom_range(3, 5)));
    end
  endtask

  task automatic pulse_break(input bit with_byte);
    @(negedge clk);
    rx_break = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data = 8'h5A;
    end
    @(negedge clk);
    rx_break = 1'b0;
    rx_valid = 1'b0;
    if (!md_done) md_bytes.delete();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == END_W) w = 32'h0;
    return w;
  endfunction

  task automatic check_writes(input string tag);
    int n;
    repeat (4) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s_data%0d", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s_cyc%0d", tag, i), 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_word_count"}, 64'(o_wc), 64'(md_addr));
    chk({tag, "_write_done"}, 64'(o_wd), 64'(md_done));
    chk({tag, "_overflow"}, 64'(o_ov), 64'(md_ovf));
    chk({tag, "_load_active"}, 64'(o_la), 64'(!md_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    @(negedge clk);

    // Single word, latency two cycles after the 4th byte edge
    reset_now(1'b0, 256);
    send_byte(8'h13, 1, 3);
    send_byte(8'h01, 1, 3);
    send_byte(8'h01, 1, 3);
    send_byte(8'hFD, 1, 3);
    check_writes("single");
    check_status("single");

    // Program load with terminator, then a second terminator
    reset_now(1'b0, 256);
    send_word(32'h0000_0000);
    send_word(32'h0000_0000);
    send_word(32'hFD01_0113);
    send_word(32'h0281_2623);
    send_word(END_W);
    repeat (4) @(negedge clk);
    check_status("term1");
    chk("term1_done_cyc", 64'(done_cyc), 64'(exp_done_cyc));
    send_word(END_W);
    check_writes("term2");
    check_status("term2");

    // rx_valid held high is one byte only
    reset_now(1'b0, 256);
    send_byte(8'hAA, 10, 3);
    send_byte(8'hBB, 1, 3);
    send_byte(8'hCC, 2, 4);
    send_byte(8'hDD, 1, 3);
    check_writes("hold");
    check_status("hold");

    // Break discards a partial word and beats a simultaneous byte edge
    reset_now(1'b0, 256);
    send_word(rand_word());
    send_byte(8'($urandom), 1, 3);
    send_byte(8'($urandom), 1, 3);
    pulse_break(1'b0);
    send_byte(8'($urandom), 2, 3);
    pulse_break(1'b1);
    send_word(32'hFFD0_0793);
    check_writes("break");
    check_status("break");

    // Randomized stream with partial 0xFF runs that must not terminate
    reset_now(1'b0, 256);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) send_word(32'h00FF_FFFF);
      else if (i == 4) send_word(32'hFFFF_FF7E);
      else send_word(rand_word());
    end
    check_writes("rand");
    check_status("rand");

    // 4-deep memory overflows on the 4th write; the 5th word is dropped
    reset_now(1'b1, 4);
    for (int i = 0; i < 5; i++) send_word(rand_word());
    check_writes("ovf");
    check_status("ovf");
    chk("ovf_done_cyc", 64'(done_cyc), 64'(exp_done_cyc));

    // Reset during a write strobe, then reset mid-word
    reset_now(1'b0, 256);
    send_byte(8'h11, 1, 3);
    send_byte(8'h22, 1, 3);
    send_byte(8'h33, 1, 3);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h44;
    @(negedge clk);
    rx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (o_we) seen = 1'b1;
      else @(negedge clk);
    end
    chk("midwrite_we_seen", 64'(seen), 64'(1));
    reset_now(1'b0, 256);
    send_byte(8'($urandom), 1, 3);
    send_byte(8'($urandom), 1, 3);
    reset_now(1'b0, 256);
    send_word(32'hC0DE_1234);
    check_writes("postrst");
    check_status("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
